// File: rtl/fifo_stream_adapter_if.sv
// Handshake bundle for fifo_stream_adapter: the FIFO read side and the outgoing stream.
// master: the adapter (issues reads, drives the stream).
// slave:  the environment (FIFO and stream sink).
interface fifo_stream_adapter_if #(
  parameter int unsigned FIFO_WIDTH = 16
);
  logic                  fifo_empty;
  logic [FIFO_WIDTH-1:0] fifo_data_out;
  logic                  fifo_underflow;
  logic                  fifo_rd_en;
  logic                  m_valid;
  logic [FIFO_WIDTH-1:0] m_data;
  logic                  m_ready;

  modport master (
    input  fifo_empty,
    input  fifo_data_out,
    input  fifo_underflow,
    input  m_ready,
    output fifo_rd_en,
    output m_valid,
    output m_data
  );

  modport slave (
    output fifo_empty,
    output fifo_data_out,
    output fifo_underflow,
    output m_ready,
    input  fifo_rd_en,
    input  m_valid,
    input  m_data
  );
endinterface

// File: rtl/fifo_stream_adapter.sv
// FIFO-to-stream adapter with a 2-entry in-order skid buffer.
// Reads are issued only when the word (plus any read still in flight) is guaranteed a
// buffer slot, so the stream can stall without losing data and still sustain one word
// per cycle when m_ready stays high.
// Optional build macro ADAPTER_STATS_EN adds the 16-bit word_cnt delivery counter port.
module fifo_stream_adapter #(
  parameter int unsigned FIFO_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  fifo_stream_adapter_if.master   bus,
  output logic                    underflow_seen
`ifdef ADAPTER_STATS_EN
  ,
  output logic [15:0]             word_cnt
`endif
);

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StTwo   = 2'd2
  } state_e;

  state_e                state_q;
  logic [FIFO_WIDTH-1:0] head_q;
  logic [FIFO_WIDTH-1:0] tail_q;
  logic                  inflight_q;
  logic                  underflow_seen_q;

  logic                  pop;
  logic                  capture;
  logic                  discard;
  logic [2:0]            occupancy;
  logic [2:0]            committed;

  // Occupancy decode of the buffer FSM
  always_comb begin
    occupancy = 3'd0;
    case (state_q)
      StOne:   occupancy = 3'd1;
      StTwo:   occupancy = 3'd2;
      default: occupancy = 3'd0;
    endcase
  end

  assign pop     = bus.m_valid & bus.m_ready;
  assign capture = inflight_q & ~bus.fifo_underflow;
  assign discard = inflight_q & bus.fifo_underflow;

  // Words that will occupy the buffer once the in-flight read lands and this cycle's pop
  // leaves; a new read is only allowed if that leaves room for it. pop implies occupancy
  // >= 1, so the subtraction cannot wrap.
  assign committed = occupancy + {2'b00, inflight_q} - {2'b00, pop};

  assign bus.fifo_rd_en = rst_n & enable & ~bus.fifo_empty & (committed < 3'd2);
  assign bus.m_valid    = (state_q != StEmpty);
  assign bus.m_data     = (state_q != StEmpty) ? head_q : '0;
  assign underflow_seen = underflow_seen_q;

  // Buffer FSM: head is always the oldest word, tail the second one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StEmpty;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      case (state_q)
        StEmpty: begin
          if (capture) begin
            head_q  <= bus.fifo_data_out;
            state_q <= StOne;
          end
        end
        StOne: begin
          if (capture && pop) begin
            head_q <= bus.fifo_data_out;
          end else if (capture) begin
            tail_q  <= bus.fifo_data_out;
            state_q <= StTwo;
          end else if (pop) begin
            state_q <= StEmpty;
          end
        end
        StTwo: begin
          // Capture without pop is excluded by the read gating
          if (pop) begin
            head_q <= tail_q;
            if (capture) begin
              tail_q <= bus.fifo_data_out;
            end else begin
              state_q <= StOne;
            end
          end
        end
        default: begin
          state_q <= StEmpty;
        end
      endcase
    end
  end

  // One read can be outstanding; its data arrives on the following cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= bus.fifo_rd_en;
    end
  end

  // Sticky record of a read that came back flagged as underflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      underflow_seen_q <= 1'b0;
    end else if (discard) begin
      underflow_seen_q <= 1'b1;
    end
  end

`ifdef ADAPTER_STATS_EN
  logic [15:0] word_cnt_q;

  // Delivered-word counter, wraps naturally at 16 bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_cnt_q <= 16'd0;
    end else if (pop) begin
      word_cnt_q <= word_cnt_q + 16'd1;
    end
  end

  assign word_cnt = word_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_stream_adapter.sv
// Self-checking bench for fifo_stream_adapter: directed scenarios followed by a random
// phase, all scored against a queue-based reference of the buffered words.
module tb_fifo_stream_adapter;

  localparam int W     = 16;
  localparam int DEPTH = 4096;

  logic clk;
  logic rst_n;
  logic enable;
  logic underflow_seen;
`ifdef ADAPTER_STATS_EN
  logic [15:0] word_cnt;
  logic [15:0] mdl_cnt;
`endif

  fifo_stream_adapter_if #(.FIFO_WIDTH(W)) bus ();

  fifo_stream_adapter #(.FIFO_WIDTH(W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .enable         (enable),
    .bus            (bus),
    .underflow_seen (underflow_seen)
`ifdef ADAPTER_STATS_EN
    ,
    .word_cnt       (word_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // External FIFO contents
  logic [W-1:0] mem [DEPTH];
  int           rd_ptr = 0;
  int           wr_ptr = 0;
  logic         inj_uf = 1'b0;

  // Reference: words captured but not yet delivered, in order
  logic [W-1:0] exp_q [$];
  logic         mdl_inflight = 1'b0;
  logic         mdl_uf       = 1'b0;

  // Observation logs for directed checks
  int pop_data [$];
  int pop_cyc  [$];
  int rd_pulses   = 0;
  int first_rd    = -1;
  int first_valid = -1;
  int cyc         = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [W-1:0] w);
    mem[wr_ptr % DEPTH] = w;
    wr_ptr++;
    bus.fifo_empty = 1'b0;
  endtask

  task automatic clear_logs();
    pop_data.delete();
    pop_cyc.delete();
    rd_pulses   = 0;
    first_rd    = -1;
    first_valid = -1;
  endtask

  // One clock cycle: check outputs at negedge, advance model at posedge, then FIFO responds
  task automatic step();
    logic         s_rd;
    logic         s_uf;
    logic         m_pop;
    logic         exp_rd;
    logic         exp_valid;
    logic [W-1:0] s_dout;
    logic [W-1:0] exp_data;
    int           pending;
    @(negedge clk);
    exp_valid = (exp_q.size() != 0);
    exp_data  = exp_valid ? exp_q[0] : '0;
    m_pop     = exp_valid && bus.m_ready;
    pending   = exp_q.size() + (mdl_inflight ? 1 : 0) - (m_pop ? 1 : 0);
    exp_rd    = enable && !bus.fifo_empty && (pending < 2);
    check("m_valid", {31'd0, bus.m_valid}, {31'd0, exp_valid});
    check("m_data", {16'd0, bus.m_data}, {16'd0, exp_data});
    check("fifo_rd_en", {31'd0, bus.fifo_rd_en}, {31'd0, exp_rd});
    check("underflow_seen", {31'd0, underflow_seen}, {31'd0, mdl_uf});
`ifdef ADAPTER_STATS_EN
    check("word_cnt", {16'd0, word_cnt}, {16'd0, mdl_cnt});
`endif
    s_rd   = bus.fifo_rd_en;
    s_dout = bus.fifo_data_out;
    s_uf   = bus.fifo_underflow;
    if (s_rd) rd_pulses++;
    if (s_rd && first_rd < 0) first_rd = cyc;
    if (bus.m_valid && first_valid < 0) first_valid = cyc;
    if (bus.m_valid && bus.m_ready) begin
      pop_data.push_back(int'(bus.m_data));
      pop_cyc.push_back(cyc);
    end
    @(posedge clk);
    if (m_pop) begin
      void'(exp_q.pop_front());
`ifdef ADAPTER_STATS_EN
      mdl_cnt = mdl_cnt + 16'd1;
`endif
    end
    if (mdl_inflight) begin
      if (s_uf) mdl_uf = 1'b1;
      else exp_q.push_back(s_dout);
    end
    mdl_inflight = s_rd;
    cyc++;
    #1;
    if (s_rd && rd_ptr != wr_ptr) begin
      bus.fifo_data_out  = mem[rd_ptr % DEPTH];
      bus.fifo_underflow = inj_uf;
      rd_ptr++;
    end else begin
      bus.fifo_data_out  = W'($urandom);
      bus.fifo_underflow = 1'b0;
    end
    bus.fifo_empty = (rd_ptr == wr_ptr);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Asynchronous reset away from the clock edge; outputs must clear immediately
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_m_valid", {31'd0, bus.m_valid}, 32'd0);
    check("rst_m_data", {16'd0, bus.m_data}, 32'd0);
    check("rst_fifo_rd_en", {31'd0, bus.fifo_rd_en}, 32'd0);
    check("rst_underflow_seen", {31'd0, underflow_seen}, 32'd0);
`ifdef ADAPTER_STATS_EN
    check("rst_word_cnt", {16'd0, word_cnt}, 32'd0);
    mdl_cnt = 16'd0;
`endif
    exp_q.delete();
    mdl_inflight       = 1'b0;
    mdl_uf             = 1'b0;
    bus.fifo_underflow = 1'b0;
    @(posedge clk);
    #1;
    check("rst_hold_valid", {31'd0, bus.m_valid}, 32'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n              = 1'b1;
    enable             = 1'b0;
    bus.fifo_empty     = 1'b1;
    bus.fifo_data_out  = '0;
    bus.fifo_underflow = 1'b0;
    bus.m_ready        = 1'b0;
`ifdef ADAPTER_STATS_EN
    mdl_cnt = 16'd0;
`endif
    do_reset();

    // Basic delivery: three words back to back, two-cycle first-word latency
    clear_logs();
    load(16'h0001);
    load(16'h0002);
    load(16'h0003);
    enable      = 1'b1;
    bus.m_ready = 1'b1;
    steps(8);
    check("basic_latency", first_valid - first_rd, 32'd2);
    check("basic_count", pop_data.size(), 32'd3);
    check("basic_w0", pop_data[0], 32'h0001);
    check("basic_w1", pop_data[1], 32'h0002);
    check("basic_w2", pop_data[2], 32'h0003);
    check("basic_consec", pop_cyc[2] - pop_cyc[0], 32'd2);

    // Stall: buffer fills with exactly two reads, then drains in order
    clear_logs();
    bus.m_ready = 1'b0;
    for (int i = 0; i < 4; i++) load(W'(16'h0010 + i));
    steps(8);
    check("stall_pulses", rd_pulses, 32'd2);
    check("stall_valid", {31'd0, bus.m_valid}, 32'd1);
    check("stall_rd_en", {31'd0, bus.fifo_rd_en}, 32'd0);
    check("stall_no_pop", pop_data.size(), 32'd0);
    bus.m_ready = 1'b1;
    steps(8);
    check("resume_count", pop_data.size(), 32'd4);
    for (int i = 0; i < 4; i++) check("resume_order", pop_data[i], 32'h0010 + i);
    check("resume_reads", rd_pulses, 32'd4);

    // Underflow on the in-flight read: word dropped, sticky flag set until reset
    do_reset();
    clear_logs();
    load(16'hBEEF);
    inj_uf = 1'b1;
    steps(5);
    inj_uf = 1'b0;
    check("uf_valid", {31'd0, bus.m_valid}, 32'd0);
    check("uf_seen", {31'd0, underflow_seen}, 32'd1);
    check("uf_no_pop", pop_data.size(), 32'd0);
    load(16'h0055);
    steps(5);
    check("uf_sticky", {31'd0, underflow_seen}, 32'd1);
    check("uf_after_word", pop_data[0], 32'h0055);

    // enable drops right after the first read: in-flight word still arrives, no more reads
    do_reset();
    clear_logs();
    load(16'h0021);
    load(16'h0022);
    load(16'h0023);
    enable      = 1'b1;
    bus.m_ready = 1'b1;
    step();
    enable = 1'b0;
    steps(6);
    check("en_pulses", rd_pulses, 32'd1);
    check("en_count", pop_data.size(), 32'd1);
    check("en_word", pop_data[0], 32'h0021);

    // Reset with a buffered word and a read in flight; both must be lost
    do_reset();
    rd_ptr = wr_ptr;
    bus.fifo_empty = 1'b1;
    clear_logs();
    enable      = 1'b1;
    bus.m_ready = 1'b0;
    for (int i = 0; i < 4; i++) load(W'(16'h0031 + i));
    steps(2);
    do_reset();
    clear_logs();
    bus.m_ready = 1'b1;
    steps(8);
    check("rst_mid_first", pop_data[0], 32'h0033);
    check("rst_mid_count", pop_data.size(), 32'd2);

    // Throughput: one word per cycle with ready held high
    do_reset();
    clear_logs();
    for (int i = 0; i < 20; i++) load(W'(16'h0100 + i));
    steps(4);
    clear_logs();
    steps(10);
    check("tput_count", pop_data.size(), 32'd10);

`ifdef ADAPTER_STATS_EN
    // Counter: five pops, then wrap from all-ones
    do_reset();
    rd_ptr = wr_ptr;
    bus.fifo_empty = 1'b1;
    for (int i = 0; i < 5; i++) load(W'(16'h0200 + i));
    steps(10);
    check("cnt_five", {16'd0, word_cnt}, 32'd5);
    force dut.word_cnt_q = 16'hFFFF;
    #1;
    release dut.word_cnt_q;
    mdl_cnt = 16'hFFFF;
    load(16'h0300);
    steps(5);
    check("cnt_wrap", {16'd0, word_cnt}, 32'd0);
`endif

    // Random traffic against the reference queue
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      bus.m_ready = ($urandom_range(0, 3) != 0);
      enable      = ($urandom_range(0, 7) != 0);
      inj_uf      = ($urandom_range(0, 63) == 0);
      if ((wr_ptr - rd_ptr) < 6 && $urandom_range(0, 1) == 1) load(W'($urandom));
      step();
    end
    inj_uf      = 1'b0;
    bus.m_ready = 1'b1;
    enable      = 1'b1;
    steps(20);
    check("rand_drained", {31'd0, bus.m_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
